// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: RAW/load-use stalls, taken-branch flushes and a
// two-state memory handshake that freezes the whole pipeline, plus perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             front_freeze,
  output logic             back_freeze,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_start,
  output logic             mem_err,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Wide enough to hold TIMEOUT-1, the last value reached before abandoning.
  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t          state_reg, state_next;
  logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic            mem_err_reg;

  logic m_src1, m_src2, l_src1, l_src2;
  logic hz, timeout_hit, mstall, case_branch, case_hazard;

  assign m_src1 = ((id_src1 == exe_dest) && exe_wb_en) || ((id_src1 == mem_dest) && mem_wb_en);
  assign m_src2 = ((id_src2 == exe_dest) && exe_wb_en) || ((id_src2 == mem_dest) && mem_wb_en);
  assign l_src1 = (id_src1 == exe_dest) && exe_mem_r_en;
  assign l_src2 = (id_src2 == exe_dest) && exe_mem_r_en;

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hz = id_valid && (fwd_en ? (l_src1 || (id_two_src && l_src2))
                                  : (m_src1 || (id_two_src && m_src2)));

  assign timeout_hit = (TIMEOUT != 0) && (state_reg == WAIT) && !mem_ready &&
                       (wait_cnt_reg == WC_W'(TIMEOUT - 1));

  assign mstall = ((state_reg == IDLE) && mem_req) ||
                  ((state_reg == WAIT) && !mem_ready && !timeout_hit);

  assign case_branch = !mstall && branch_taken;
  assign case_hazard = !mstall && !branch_taken && hz;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout_hit)
        mem_err_reg <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (!mem_ready)
          wait_cnt_next = wait_cnt_reg + 1'b1;
        if (mem_ready || timeout_hit)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_start    = (state_reg == IDLE) && mem_req;
    front_freeze = 1'b0;
    back_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (mstall) begin
      front_freeze = 1'b1;
      back_freeze  = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hz) begin
      front_freeze = 1'b1;
      idex_flush   = 1'b1;
    end
  end

  assign mem_err = mem_err_reg;

  // Saturating counters: 0 = hazard stalls, 1 = branch flushes, 2 = memory waits.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  assign cnt_inc = {mstall, case_branch, case_hazard};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_clr)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign hazard_cnt  = cnt_reg[0];
  assign flush_cnt   = cnt_reg[1];
  assign memwait_cnt = cnt_reg[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with 2-bit counters and a
// 4-cycle memory timeout so saturation and abandonment are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 4;
  localparam int CNT_W = 2;

  logic             clk, rst;
  logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic             id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             fwd_en, branch_taken, mem_req, mem_ready, cnt_clr;
  logic             front_freeze, back_freeze, ifid_flush, idex_flush, mem_start, mem_err;
  logic [CNT_W-1:0] hazard_cnt, flush_cnt, memwait_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .front_freeze(front_freeze), .back_freeze(back_freeze),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_start(mem_start), .mem_err(mem_err),
    .hazard_cnt(hazard_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_src1 = '0; id_src2 = '0; id_two_src = 0; id_valid = 0;
    exe_dest = '0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = '0; mem_wb_en = 0; fwd_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic set_load_use();
    set_idle();
    fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3; id_src1 = 4'd3; id_valid = 1;
  endtask

  task automatic test_reset();
    rst = 1; set_idle();
    #2;
    tests++; if ({front_freeze, back_freeze, ifid_flush, idex_flush, mem_start, mem_err} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %b required 000000",
        {front_freeze, back_freeze, ifid_flush, idex_flush, mem_start, mem_err}); end
    tests++; if ({hazard_cnt, flush_cnt, memwait_cnt} !== 6'b0) begin
      fails++; $display("FAIL reset_counters: got %h/%h/%h required 0/0/0", hazard_cnt, flush_cnt, memwait_cnt); end
    cyc(); cyc();
    rst = 0;
    cyc();
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    tests++; if ({front_freeze, back_freeze, ifid_flush, idex_flush} !== 4'b1001) begin
      fails++; $display("FAIL load_use_stall: got ff/bf/if/ix=%b required 1001",
        {front_freeze, back_freeze, ifid_flush, idex_flush}); end
    cyc();
    tests++; if (hazard_cnt !== 2'd1) begin
      fails++; $display("FAIL load_use_cnt: got %0d required 1", hazard_cnt); end
    exe_mem_r_en = 0;
    #1;
    tests++; if ({front_freeze, back_freeze, ifid_flush, idex_flush} !== 4'b0000) begin
      fails++; $display("FAIL no_load_no_stall: got %b required 0000",
        {front_freeze, back_freeze, ifid_flush, idex_flush}); end
    cyc();
    tests++; if (hazard_cnt !== 2'd1) begin
      fails++; $display("FAIL no_load_cnt: got %0d required 1", hazard_cnt); end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_nofwd_src2();
    set_idle();
    mem_dest = 4'd5; mem_wb_en = 1; id_src2 = 4'd5; id_src1 = 4'd1; exe_dest = 4'd3;
    id_two_src = 1; id_valid = 0;
    #1;
    tests++; if (front_freeze !== 1'b0) begin
      fails++; $display("FAIL bubble_no_stall: got %b required 0", front_freeze); end
    id_valid = 1; id_two_src = 0;
    #1;
    tests++; if ({front_freeze, idex_flush} !== 2'b00) begin
      fails++; $display("FAIL one_src_no_stall: got %b required 00", {front_freeze, idex_flush}); end
    id_two_src = 1;
    #1;
    tests++; if ({front_freeze, back_freeze, ifid_flush, idex_flush} !== 4'b1001) begin
      fails++; $display("FAIL src2_stall: got %b required 1001",
        {front_freeze, back_freeze, ifid_flush, idex_flush}); end
    cyc();
    tests++; if (hazard_cnt !== 2'd2) begin
      fails++; $display("FAIL src2_cnt: got %0d required 2", hazard_cnt); end
    $display("[TB] test_nofwd_src2 done");
  endtask

  task automatic test_branch_over_hazard();
    set_idle();
    mem_dest = 4'd5; mem_wb_en = 1; id_src2 = 4'd5; id_two_src = 1; id_valid = 1;
    branch_taken = 1;
    #1;
    tests++; if ({front_freeze, back_freeze, ifid_flush, idex_flush} !== 4'b0011) begin
      fails++; $display("FAIL branch_flush: got %b required 0011",
        {front_freeze, back_freeze, ifid_flush, idex_flush}); end
    cyc();
    tests++; if ({flush_cnt, hazard_cnt} !== {2'd1, 2'd2}) begin
      fails++; $display("FAIL branch_cnts: got flush=%0d hazard=%0d required 1/2", flush_cnt, hazard_cnt); end
    set_idle();
    $display("[TB] test_branch_over_hazard done");
  endtask

  task automatic test_counters();
    set_load_use();
    cnt_clr = 1;
    cyc();
    tests++; if ({hazard_cnt, flush_cnt, memwait_cnt} !== 6'b0) begin
      fails++; $display("FAIL clr_priority: got %h/%h/%h required 0/0/0", hazard_cnt, flush_cnt, memwait_cnt); end
    cnt_clr = 0;
    for (int i = 0; i < 5; i++) cyc();
    tests++; if (hazard_cnt !== 2'd3) begin
      fails++; $display("FAIL hazard_saturate: got %0d required 3", hazard_cnt); end
    set_idle();
    $display("[TB] test_counters done");
  endtask

  task automatic test_mem_handshake();
    set_idle();
    cnt_clr = 1; cyc(); cnt_clr = 0;
    mem_req = 1; branch_taken = 1;
    #1;
    tests++; if ({mem_start, front_freeze, back_freeze, ifid_flush, idex_flush} !== 5'b11100) begin
      fails++; $display("FAIL hs_cycle0: got st/ff/bf/if/ix=%b required 11100",
        {mem_start, front_freeze, back_freeze, ifid_flush, idex_flush}); end
    cyc();
    mem_req = 0;
    for (int c = 1; c < 3; c++) begin
      #1;
      tests++; if ({mem_start, front_freeze, back_freeze, ifid_flush, idex_flush} !== 5'b01100) begin
        fails++; $display("FAIL hs_cycle%0d: got %b required 01100", c,
          {mem_start, front_freeze, back_freeze, ifid_flush, idex_flush}); end
      cyc();
    end
    branch_taken = 0; mem_ready = 1;
    #1;
    tests++; if ({mem_start, front_freeze, back_freeze} !== 3'b000) begin
      fails++; $display("FAIL hs_cycle3: got st/ff/bf=%b required 000", {mem_start, front_freeze, back_freeze}); end
    cyc();
    tests++; if ({memwait_cnt, flush_cnt} !== {2'd3, 2'd0}) begin
      fails++; $display("FAIL hs_cnts: got memwait=%0d flush=%0d required 3/0", memwait_cnt, flush_cnt); end
    $display("[TB] test_mem_handshake done");
  endtask

  task automatic test_back_to_back();
    mem_ready = 0; mem_req = 1;
    #1;
    tests++; if ({mem_start, back_freeze} !== 2'b11) begin
      fails++; $display("FAIL b2b_start: got st/bf=%b required 11", {mem_start, back_freeze}); end
    cyc();
    mem_req = 0; mem_ready = 1;
    #1;
    tests++; if ({mem_start, back_freeze} !== 2'b00) begin
      fails++; $display("FAIL b2b_done: got st/bf=%b required 00", {mem_start, back_freeze}); end
    cyc();
    mem_ready = 0;
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_timeout();
    set_idle();
    cnt_clr = 1; cyc(); cnt_clr = 0;
    mem_req = 1;
    #1;
    tests++; if ({mem_start, back_freeze} !== 2'b11) begin
      fails++; $display("FAIL to_cycle0: got st/bf=%b required 11", {mem_start, back_freeze}); end
    cyc();
    mem_req = 0;
    for (int c = 1; c < 4; c++) begin
      #1;
      tests++; if ({front_freeze, back_freeze} !== 2'b11) begin
        fails++; $display("FAIL to_cycle%0d: got ff/bf=%b required 11", c, {front_freeze, back_freeze}); end
      cyc();
    end
    #1;
    tests++; if ({front_freeze, back_freeze, mem_err} !== 3'b000) begin
      fails++; $display("FAIL to_cycle4: got ff/bf/err=%b required 000", {front_freeze, back_freeze, mem_err}); end
    cyc();
    tests++; if ({back_freeze, mem_err, memwait_cnt} !== {1'b0, 1'b1, 2'd3}) begin
      fails++; $display("FAIL to_cycle5: got bf=%b err=%b memwait=%0d required 0/1/3",
        back_freeze, mem_err, memwait_cnt); end
    mem_req = 1;
    #1;
    tests++; if (mem_start !== 1'b1) begin
      fails++; $display("FAIL to_idle: got mem_start=%b required 1", mem_start); end
    mem_req = 0;
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    tests++; if ({mem_err, hazard_cnt, flush_cnt, memwait_cnt} !== 7'b1000000) begin
      fails++; $display("FAIL clr_keeps_err: got err=%b cnts=%h/%h/%h required 1/0/0/0",
        mem_err, hazard_cnt, flush_cnt, memwait_cnt); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_reset_mid();
    set_idle();
    mem_req = 1;
    cyc();
    mem_req = 0;
    #1;
    tests++; if ({back_freeze, memwait_cnt} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL mid_wait: got bf=%b memwait=%0d required 1/1", back_freeze, memwait_cnt); end
    rst = 1;
    #1;
    tests++; if ({front_freeze, back_freeze, mem_err, memwait_cnt} !== 5'b00000) begin
      fails++; $display("FAIL mid_reset: got ff=%b bf=%b err=%b memwait=%0d required 0/0/0/0",
        front_freeze, back_freeze, mem_err, memwait_cnt); end
    cyc();
    rst = 0; mem_ready = 1;
    #1;
    tests++; if ({mem_start, back_freeze} !== 2'b00) begin
      fails++; $display("FAIL stray_ready: got st/bf=%b required 00", {mem_start, back_freeze}); end
    cyc();
    tests++; if (memwait_cnt !== 2'd0) begin
      fails++; $display("FAIL stray_ready_cnt: got %0d required 0", memwait_cnt); end
    set_idle();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_nofwd_src2();
    test_branch_over_hazard();
    test_counters();
    test_mem_handshake();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing block for the 5-stage pipeline.
- Generates freeze and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Combines three sources:
  - RAW hazard detection for the instruction in ID, with forwarding-aware load-use detection.
  - Taken-branch flushing from EXE.
  - A two-state handshake FSM that holds the whole pipeline while the MEM stage waits on the external memory controller.
- Also keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- REG_W, 4, width of register specifiers.
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 255, maximum WAIT cycles before a transaction is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_src1  in  REG_W  first source register of the ID instruction
- id_src2  in  REG_W  second source register of the ID instruction
- id_two_src  in  1  ID instruction reads id_src2
- id_valid  in  1  ID holds a real, non-bubble instruction
- exe_dest  in  REG_W  destination register in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  REG_W  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- fwd_en  in  1  forwarding unit enabled
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM instruction reads or writes memory
- mem_ready  in  1  memory controller completion
- cnt_clr  in  1  synchronous clear of all counters
- front_freeze  out  1  hold PC and IF/ID
- back_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- ifid_flush  out  1  load a bubble into IF/ID
- idex_flush  out  1  load a bubble into ID/EX
- mem_start  out  1  one-cycle transaction start pulse
- mem_err  out  1  sticky timeout flag
- hazard_cnt  out  CNT_W  hazard stall cycles
- flush_cnt  out  CNT_W  taken-branch flush events
- memwait_cnt  out  CNT_W  cycles with back_freeze high

Behaviour:
- **Reset:** state=IDLE, wait counter=0, mem_err=0, all counters=0. Registered outputs are 0; combinational outputs follow from the reset state.
- **Hazard term hz.** hz is 0 unless id_valid=1. Define m(x) = (x==exe_dest & exe_wb_en) | (x==mem_dest & mem_wb_en). Define l(x) = (x==exe_dest & exe_mem_r_en).
  - fwd_en=0: hz = m(id_src1) | (id_two_src & m(id_src2)).
  - fwd_en=1: hz = l(id_src1) | (id_two_src & l(id_src2)).
- **Memory FSM (two states, transitions registered):**
  - IDLE: when mem_req=1, mem_start=1 combinationally, next state is WAIT, wait counter cleared.
  - WAIT: when mem_ready=1, next state is IDLE. When mem_ready=0, the wait counter increments. If TIMEOUT!=0 and the counter == TIMEOUT-1, next state is IDLE and mem_err<=1 (sticky until rst); that cycle counts as completion.
  - A memory access therefore costs at least 2 cycles.
  - mem_req arriving in the IDLE cycle right after a completion starts a new transaction; no lockout.
- **mstall** (combinational) = (IDLE & mem_req) | (WAIT & ~mem_ready & ~timeout_hit).
- **Output priority (combinational):**
  1. mstall: front_freeze=1, back_freeze=1, ifid_flush=0, idex_flush=0. Branch and hazard requests are held off because the stage registers do not advance.
  2. else branch_taken: ifid_flush=1, idex_flush=1, front_freeze=0. Branch overrides hz because the ID instruction is wrong-path.
  3. else hz: front_freeze=1, idex_flush=1.
  4. else all outputs 0.
- **Counters (registered, saturate at all-ones):**
  - hazard_cnt increments on each cycle of case 3.
  - flush_cnt increments on each cycle of case 2.
  - memwait_cnt increments on each cycle of mstall.
  - cnt_clr has priority over increments; it does not clear mem_err.
- **Reset mid-transaction:** rst in WAIT returns to IDLE immediately and releases all freezes. An outstanding mem_ready arriving in IDLE is ignored.

Test Plan:
- **Load-use hazard:** fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_valid=1 → front_freeze=1, idex_flush=1, hazard_cnt 0→1. Same with exe_mem_r_en=0 → all outputs 0.
- **Non-forwarding hazard on src2:** fwd_en=0, mem_dest=5, mem_wb_en=1, id_src2=5.
  - id_two_src=0 → no stall.
  - id_two_src=1 → stall.
- **Branch overrides hazard:** branch_taken=1 with hz=1 → ifid_flush=1, idex_flush=1, front_freeze=0, flush_cnt+1, hazard_cnt unchanged.
- **Memory handshake:** mem_req=1 at cycle 0, mem_ready high at cycle 3 → mem_start only at cycle 0, back_freeze=1 for cycles 0–2 and 0 at cycle 3, memwait_cnt=3. branch_taken asserted during cycles 0–2 produces no flush.
- **Timeout:** TIMEOUT=4, mem_ready never asserted → freeze during cycles 0–3, released at cycle 4, mem_err=1 from cycle 5, state IDLE. cnt_clr leaves mem_err=1 and zeroes the counters.
- **Saturation and reset:** CNT_W=2 with 5 hazard cycles → hazard_cnt=3. rst asserted in WAIT → back_freeze=0 immediately and counters=0.
